// File: rtl/frame_sequencer.sv
// Frame sequencer: latches a shadow viewport config, launches one scheduler frame per
// request (single or back-to-back run), and tracks completions and a frame watchdog.
module frame_sequencer #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 16,
    parameter int H_RES  = 320,
    parameter int V_RES  = 172,
    parameter int TO_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  cfg_view_x,
    input  logic [WIDTH-1:0]  cfg_view_y,
    input  logic [WIDTH-1:0]  cfg_step,
    input  logic [ITER_W-1:0] cfg_max_iter,
    input  logic              cfg_commit,
    input  logic              ctrl_run,
    input  logic              ctrl_single,
    input  logic              irq_clr,
    output logic              frame_start,
    input  logic              sched_busy,
    input  logic              sched_done,
    output logic [WIDTH-1:0]  c_re_start,
    output logic [WIDTH-1:0]  c_im_start,
    output logic [WIDTH-1:0]  c_re_step,
    output logic [WIDTH-1:0]  c_im_step,
    output logic [ITER_W-1:0] max_iter,
    output logic              seq_busy,
    output logic [15:0]       frame_count,
    output logic              irq_frame,
    output logic              err_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] HALF_H = WIDTH'(H_RES / 2);
    localparam logic [WIDTH-1:0] HALF_V = WIDTH'(V_RES / 2);
    localparam logic [TO_W-1:0]  WD_MAX = '1;

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_sh_x, r_sh_y, r_sh_step;
    logic [ITER_W-1:0]   r_sh_iter;
    logic [WIDTH-1:0]    r_re_start, r_im_start, r_step;
    logic [ITER_W-1:0]   r_max_iter;
    logic [15:0]         r_frame_count;
    logic                r_irq, r_err;
    logic [TO_W-1:0]     r_wd;

    logic [WIDTH-1:0]    w_re_off, w_im_off;
    logic [TO_W-1:0]     w_wd_inc;
    logic                w_in_wd, w_wd_hit;

    // Offsets wrap to WIDTH bits, matching two's-complement fixed-point arithmetic.
    assign w_re_off = r_sh_step * HALF_H;
    assign w_im_off = r_sh_step * HALF_V;
    assign w_in_wd  = (r_state == S_WAIT_ACK) || (r_state == S_RUN);
    assign w_wd_inc = r_wd + TO_W'(1);
    // Flag fires once on the step into all-ones; the saturated count does not re-fire it.
    assign w_wd_hit = w_in_wd && (r_wd != WD_MAX) && (w_wd_inc == WD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (ctrl_single || ctrl_run) w_next = S_LOAD;
            S_LOAD:     w_next = S_START;
            S_START:    w_next = S_WAIT_ACK;
            S_WAIT_ACK: if (sched_busy) w_next = S_RUN;
            S_RUN:      if (sched_done) w_next = S_DONE;
            S_DONE:     w_next = ctrl_run ? S_LOAD : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        frame_start = (r_state == S_START);
        seq_busy    = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_x        <= '0;
            r_sh_y        <= '0;
            r_sh_step     <= '0;
            r_sh_iter     <= '0;
            r_re_start    <= '0;
            r_im_start    <= '0;
            r_step        <= '0;
            r_max_iter    <= '0;
            r_frame_count <= '0;
            r_irq         <= 1'b0;
            r_err         <= 1'b0;
            r_wd          <= '0;
        end else begin
            if (cfg_commit) begin
                r_sh_x    <= cfg_view_x;
                r_sh_y    <= cfg_view_y;
                r_sh_step <= cfg_step;
                r_sh_iter <= cfg_max_iter;
            end
            if (r_state == S_LOAD) begin
                r_re_start <= r_sh_x - w_re_off;
                r_im_start <= r_sh_y - w_im_off;
                r_step     <= r_sh_step;
                r_max_iter <= (r_sh_iter == '0) ? ITER_W'(1) : r_sh_iter;
            end
            if (r_state == S_START)                r_wd <= '0;
            else if (w_in_wd && (r_wd != WD_MAX))  r_wd <= w_wd_inc;
            if (r_state == S_DONE) r_frame_count <= r_frame_count + 16'd1;
            if (r_state == S_DONE) r_irq <= 1'b1;
            else if (irq_clr)      r_irq <= 1'b0;
            if (w_wd_hit)          r_err <= 1'b1;
            else if (irq_clr)      r_err <= 1'b0;
        end
    end

    assign c_re_start  = r_re_start;
    assign c_im_start  = r_im_start;
    assign c_re_step   = r_step;
    assign c_im_step   = r_step;
    assign max_iter    = r_max_iter;
    assign frame_count = r_frame_count;
    assign irq_frame   = r_irq;
    assign err_timeout = r_err;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: scheduler model on the falling edge, per-frame expected
// viewport pushed on request and popped on each frame_start.
module tb_frame_sequencer;
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [31:0] st;
        logic [15:0] it;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_view_x = '0, cfg_view_y = '0, cfg_step = '0;
    logic [15:0] cfg_max_iter = '0;
    logic        cfg_commit = 1'b0, ctrl_run = 1'b0, ctrl_single = 1'b0, irq_clr = 1'b0;
    logic        sched_busy = 1'b0, sched_done = 1'b0;
    logic        frame_start, seq_busy, irq_frame, err_timeout;
    logic [31:0] c_re_start, c_im_start, c_re_step, c_im_step;
    logic [15:0] max_iter, frame_count;

    int   n_vec = 0, n_err = 0, n_starts = 0, cnt = 0;
    logic pend = 1'b0, hold = 1'b0, rel_done = 1'b0;
    exp_t q[$];

    frame_sequencer #(.TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_view_x(cfg_view_x), .cfg_view_y(cfg_view_y), .cfg_step(cfg_step),
        .cfg_max_iter(cfg_max_iter), .cfg_commit(cfg_commit),
        .ctrl_run(ctrl_run), .ctrl_single(ctrl_single), .irq_clr(irq_clr),
        .frame_start(frame_start), .sched_busy(sched_busy), .sched_done(sched_done),
        .c_re_start(c_re_start), .c_im_start(c_im_start),
        .c_re_step(c_re_step), .c_im_step(c_im_step), .max_iter(max_iter),
        .seq_busy(seq_busy), .frame_count(frame_count),
        .irq_frame(irq_frame), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] s, input logic [15:0] it);
        logic [63:0] ph, pv;
        exp_t e;
        ph   = s * 64'd160;
        pv   = s * 64'd86;
        e.re = x - ph[31:0];
        e.im = y - pv[31:0];
        e.st = s;
        e.it = it;
        return e;
    endfunction

    // Scheduler model: busy one cycle after start, done ~100 cycles later unless held.
    always @(negedge clk) begin
        exp_t e;
        sched_done = 1'b0;
        if (!rst_n) begin
            sched_busy = 1'b0;
            pend = 1'b0;
            cnt = 0;
        end else if (frame_start) begin
            n_starts++;
            if (q.size() == 0) begin
                chk("start_unexpected", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("re_start", c_re_start, e.re);
                chk("im_start", c_im_start, e.im);
                chk("re_step",  c_re_step,  e.st);
                chk("im_step",  c_im_step,  e.st);
                chk("max_iter", max_iter,   e.it);
            end
            pend = 1'b1;
        end else if (pend) begin
            pend = 1'b0;
            sched_busy = 1'b1;
            cnt = 100;
        end else if (sched_busy) begin
            if (cnt != 0) cnt--;
            if ((cnt == 0 && !hold) || rel_done) begin
                sched_done = 1'b1;
                sched_busy = 1'b0;
            end
        end
    end

    task automatic commit(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] s, input logic [15:0] it);
        @(posedge clk); #1;
        cfg_view_x = x; cfg_view_y = y; cfg_step = s; cfg_max_iter = it;
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
    endtask

    task automatic pulse_single();
        @(posedge clk); #1 ctrl_single = 1'b1;
        @(posedge clk); #1 ctrl_single = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_starts >= target) break;
        end
        chk("wait_start", 64'(n_starts), 64'(target));
    endtask

    task automatic wait_fc(input logic [15:0] target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (frame_count == target) break;
        end
        chk("wait_frame_done", frame_count, target);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_seq_busy"},    seq_busy,    0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_irq"},         irq_frame,   0);
        chk({tag, "_err"},         err_timeout, 0);
        chk({tag, "_re_start"},    c_re_start,  0);
        chk({tag, "_im_start"},    c_im_start,  0);
        chk({tag, "_step"},        c_re_step,   0);
        chk({tag, "_max_iter"},    max_iter,    0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // single frame, reference viewport
        commit(32'h0, 32'h0, 32'h0001_0000, 16'd256);
        q.push_back('{32'hFF60_0000, 32'hFFAA_0000, 32'h0001_0000, 16'd256});
        pulse_single();
        wait_fc(16'd1, 300);
        repeat (5) @(negedge clk);
        chk("single_fc",     frame_count, 1);
        chk("single_irq",    irq_frame,   1);
        chk("single_busy",   seq_busy,    0);
        chk("single_starts", 64'(n_starts), 1);
        chk("single_hold",   c_re_start,  32'hFF60_0000);
        pulse_clr();
        @(negedge clk) chk("irq_cleared", irq_frame, 0);

        // three run frames, new config committed during frame 2
        q.push_back(mk(32'h0, 32'h0, 32'h0001_0000, 16'd256));
        q.push_back(mk(32'h0, 32'h0, 32'h0001_0000, 16'd256));
        @(posedge clk); #1 ctrl_run = 1'b1;
        wait_starts(3, 400);
        repeat (10) @(posedge clk);
        commit(32'h1000_0000, 32'hF000_0000, 32'h0000_8000, 16'd512);
        q.push_back(mk(32'h1000_0000, 32'hF000_0000, 32'h0000_8000, 16'd512));
        @(negedge clk) chk("hold_step_midframe", c_re_step, 32'h0001_0000);
        wait_starts(4, 400);
        repeat (5) @(posedge clk);
        #1 ctrl_run = 1'b0;
        wait_fc(16'd4, 400);
        repeat (5) @(negedge clk);
        chk("run_fc",     frame_count, 4);
        chk("run_busy",   seq_busy,    0);
        chk("run_starts", 64'(n_starts), 4);
        chk("run_q_empty", 64'(q.size()), 0);

        // max_iter of zero is promoted to one
        commit(32'h0, 32'h0, 32'h0001_0000, 16'd0);
        q.push_back(mk(32'h0, 32'h0, 32'h0001_0000, 16'd1));
        pulse_single();
        wait_fc(16'd5, 300);
        repeat (3) @(negedge clk);
        chk("iter0_out", max_iter, 1);

        // watchdog: done withheld, then released with irq_clr in the DONE cycle
        pulse_clr();
        @(posedge clk); #1 hold = 1'b1;
        commit(32'h0, 32'h0, 32'h0001_0000, 16'd256);
        q.push_back(mk(32'h0, 32'h0, 32'h0001_0000, 16'd256));
        pulse_single();
        wait_starts(6, 50);
        repeat (250) @(posedge clk);
        #1 chk("wd_early_err", err_timeout, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("wd_err",       err_timeout, 1);
        chk("wd_still_busy", seq_busy,   1);
        rel_done = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b1; rel_done = 1'b0; hold = 1'b0;
        @(posedge clk); #1 irq_clr = 1'b0;
        @(negedge clk);
        chk("wd_irq_wins", irq_frame,   1);
        chk("wd_err_clr",  err_timeout, 0);
        chk("wd_fc",       frame_count, 6);

        // asynchronous reset in the middle of a frame
        q.push_back(mk(32'h0, 32'h0, 32'h0001_0000, 16'd256));
        pulse_single();
        wait_starts(7, 50);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle",   seq_busy, 0);
        chk("post_rst_starts", 64'(n_starts), 7);
        commit(32'h0020_0000, 32'hFFE0_0000, 32'h0000_4000, 16'd64);
        q.push_back(mk(32'h0020_0000, 32'hFFE0_0000, 32'h0000_4000, 16'd64));
        pulse_single();
        wait_fc(16'd1, 300);
        repeat (3) @(negedge clk);
        chk("clean_fc",      frame_count, 1);
        chk("clean_busy",    seq_busy,    0);
        chk("clean_starts",  64'(n_starts), 8);
        chk("clean_q_empty", 64'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line: WIDTH 32 coordinate width (Q4.28); ITER_W 16 iteration-count width; H_RES 320 pixels per row; V_RES 172 rows; TO_W 24 watchdog counter width.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all logic rising-edge.
  rst_n  in  1  asynchronous, active-low reset.
  cfg_view_x  in  WIDTH  viewport centre, real part (signed).
  cfg_view_y  in  WIDTH  viewport centre, imaginary part (signed).
  cfg_step  in  WIDTH  pixel pitch (signed).
  cfg_max_iter  in  ITER_W  iteration limit.
  cfg_commit  in  1  pulse: copy cfg_* into the shadow set.
  ctrl_run  in  1  level: render frames back-to-back.
  ctrl_single  in  1  pulse: render exactly one frame.
  irq_clr  in  1  pulse: clear irq_frame and err_timeout.
  frame_start  out  1  one-cycle start pulse to the pixel scheduler.
  sched_busy  in  1  scheduler frame_busy.
  sched_done  in  1  scheduler frame_done pulse.
  c_re_start, c_im_start, c_re_step, c_im_step  out  WIDTH each  per-frame viewport to the scheduler.
  max_iter  out  ITER_W  per-frame iteration limit.
  seq_busy  out  1  high in every state except IDLE.
  frame_count  out  16  frames completed, wraps.
  irq_frame  out  1  sticky frame-complete flag.
  err_timeout  out  1  sticky watchdog flag.

Function
REQ-003 On cfg_commit, the block SHALL copy all cfg_* inputs into a shadow set; commits in any state affect only the next LOAD.
REQ-004 States: IDLE, LOAD, START, WAIT_ACK, RUN, DONE.
REQ-005 IDLE SHALL go to LOAD when ctrl_single is high or ctrl_run is high; otherwise it SHALL stay in IDLE.
REQ-006 LOAD (1 cycle) SHALL register the viewport outputs from the shadow set:
  c_re_start = view_x - (H_RES/2)*step;
  c_im_start = view_y - (V_RES/2)*step;
  c_re_step = c_im_step = step.
  Products and differences wrap to WIDTH bits (two's complement, low WIDTH bits kept).
REQ-007 LOAD SHALL set max_iter = shadow max_iter, with 0 replaced by 1.
REQ-008 If cfg_commit and LOAD coincide, LOAD SHALL use the pre-commit shadow values.
REQ-009 START SHALL assert frame_start for exactly one cycle, then go to WAIT_ACK.
REQ-010 WAIT_ACK SHALL go to RUN on the first cycle sched_busy=1; frame_start SHALL NOT be re-asserted.
REQ-011 Viewport outputs and max_iter SHALL hold constant from the end of LOAD until the next LOAD.
REQ-012 RUN SHALL go to DONE on sched_done=1.
REQ-013 DONE (1 cycle) SHALL:
  increment frame_count (0xFFFF wraps to 0);
  set irq_frame;
  go to LOAD if ctrl_run=1, else to IDLE.
REQ-014 ctrl_run deasserted mid-frame SHALL let the current frame complete, then return to IDLE.
REQ-015 ctrl_single outside IDLE SHALL be ignored.
REQ-016 Watchdog: a TO_W-bit counter SHALL clear on entry to WAIT_ACK and increment each cycle in WAIT_ACK and RUN.
REQ-017 When the watchdog reaches all-ones, the block SHALL set err_timeout and saturate the counter; the state SHALL NOT change (the frame may still complete).
REQ-018 irq_clr SHALL clear irq_frame and err_timeout; a set condition in the same cycle SHALL win.
REQ-019 sched_done seen outside RUN SHALL be ignored.

Reset
REQ-020 rst_n low SHALL asynchronously force:
  state IDLE;
  all outputs 0 (frame_start, seq_busy, frame_count, irq_frame, err_timeout, viewport outputs, max_iter);
  shadow set 0;
  watchdog 0.
  This applies mid-frame, with no frame_start issued.
REQ-021 After rst_n rises, the block SHALL act only on new ctrl_single/ctrl_run activity.

Verification
REQ-022 Commit view_x=0, view_y=0, step=0x00010000, max_iter=256; pulse ctrl_single -> one frame_start pulse, with c_re_start=0xFF600000, c_im_start=0xFFAA0000, max_iter=256.
REQ-023 Scheduler model with busy 1 cycle after start and done after 100 cycles -> frame_count=1, irq_frame=1, seq_busy=0, no second frame_start.
REQ-024 ctrl_run=1 for 3 frames, with a commit of a new step during frame 2 -> frame 3 uses the new step and frames 1-2 keep the old one; dropping ctrl_run in frame 3 gives IDLE after done, frame_count=3.
REQ-025 Commit max_iter=0 -> max_iter output is 1.
REQ-026 sched_done withheld (TO_W=8) -> err_timeout=1 at the 255th cycle; a later done still completes the frame; irq_clr coinciding with done leaves irq_frame=1 and err_timeout=0.
REQ-027 rst_n low in RUN -> all outputs are 0 immediately and the block is IDLE; a following ctrl_single starts a clean frame.
